// File: rtl/board_prog_loader.sv
// rtl/board_prog_loader.sv - board-side halfword-entry writer for miniRISC memory
//
// While load_en is high the processor is held and the operator keys 32-bit
// words as two 16-bit halves on sw, low half first, each confirmed by a
// debounced press of button. Every completed word produces one single-cycle
// write to mem_addr, starting at the address on add and incrementing.
//
// Optional build macro: LOADER_CHECKSUM_EN enables the running 16-bit
// checksum on chksum; without it chksum is a constant zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_en           load-mode switch (1 = hold CPU, accept entries)
//   button            raw asynchronous pushbutton
//   add               start word address, sampled on entry to load mode
//   sw                halfword entry switches
//   cpu_hold          processor stall, high outside IDLE
//   mem_we            one-cycle memory write enable
//   mem_addr          write address (holds last value)
//   mem_wdata         write data {high half, low half} (holds last value)
//   half_sel          1 while waiting for the high half
//   word_count        words written in this session
//   full              top address written, further entries ignored
//   chksum            running checksum of written halves
module board_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              button,
    input  logic [ADDR_W-1:0] add,
    input  logic [15:0]       sw,
    output logic              cpu_hold,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              half_sel,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic [15:0]       chksum
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [ADDR_W:0] WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WRITE,
        S_FULL
    } state_t;

    state_t            state;
    logic              sync0, sync1;
    logic              db_level, db_prev;
    logic [CW-1:0]     db_cnt;
    logic              press;
    logic [15:0]       lo_reg;
    logic [ADDR_W-1:0] addr_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       chksum_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            db_level   <= 1'b0;
            db_prev    <= 1'b0;
            db_cnt     <= '0;
            press      <= 1'b0;
            lo_reg     <= '0;
            addr_reg   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            chksum_q   <= '0;
`endif
        end else begin
            sync0 <= button;
            sync1 <= sync0;

            // The level only flips after DB_CYCLES consecutive disagreeing samples.
            if (sync1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            db_prev <= db_level;
            press   <= db_level & ~db_prev;

            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        state      <= S_LO;
                        addr_reg   <= add;
                        word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chksum_q   <= '0;
`endif
                    end
                end
                S_LO: begin
                    if (!load_en) begin
                        state <= S_IDLE;
                    end else if (press) begin
                        lo_reg <= sw;
                        state  <= S_HI;
                    end
                end
                S_HI: begin
                    if (!load_en) begin
                        state <= S_IDLE;
                    end else if (press) begin
                        // The upper half of mem_wdata doubles as the high-half register.
                        mem_addr  <= addr_reg;
                        mem_wdata <= {sw, lo_reg};
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_reg <= addr_reg + 1'b1;
                    if (word_count != WC_MAX) begin
                        word_count <= word_count + 1'b1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    chksum_q <= chksum_q + mem_wdata[31:16] + mem_wdata[15:0];
`endif
                    if (addr_reg == {ADDR_W{1'b1}}) begin
                        state <= S_FULL;
                    end else if (load_en) begin
                        state <= S_LO;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FULL: begin
                    if (!load_en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cpu_hold = (state != S_IDLE);
    assign mem_we   = (state == S_WRITE);
    assign half_sel = (state == S_HI);
    assign full     = (state == S_FULL);

`ifdef LOADER_CHECKSUM_EN
    assign chksum = chksum_q;
`else
    assign chksum = 16'h0000;
`endif

endmodule

// File: tb/tb_board_prog_loader.sv
// tb/tb_board_prog_loader.sv - self-checking bench for board_prog_loader
module tb_board_prog_loader;

    localparam int AW = 10;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic          button = 1'b0;
    logic [AW-1:0] add = '0;
    logic [15:0]   sw = '0;
    logic          cpu_hold, mem_we, half_sel, full;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic [15:0]   chksum;

    int total = 0;
    int bad   = 0;
    int n_writes = 0;

    board_prog_loader #(.ADDR_W(AW), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .button(button), .add(add), .sw(sw),
        .cpu_hold(cpu_hold), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .half_sel(half_sel), .word_count(word_count), .full(full), .chksum(chksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic          new_sess;
        logic [AW-1:0] add;
        logic [15:0]   lo;
        logic [15:0]   hi;
        logic [AW-1:0] exp_addr;
        logic [AW:0]   exp_wc;
        logic          exp_full;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [15:0] v);
        sw = v;
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(10);
    endtask

    task automatic start_session(input logic [AW-1:0] a);
        load_en = 1'b0;
        tick(2);
        add = a;
        load_en = 1'b1;
        tick(2);
    endtask

    // Scoreboard: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            n_writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write actual=%0h:%0h required=%0h:%0h", mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        int k;
        int exp_writes;

        vecs[0] = '{1'b1, 10'h005, 16'h1234, 16'hABCD, 10'h005, 11'd1, 1'b0};
        vecs[1] = '{1'b0, 10'h000, 16'h0001, 16'h0002, 10'h006, 11'd2, 1'b0};
        vecs[2] = '{1'b1, 10'h3FE, 16'h5555, 16'hAAAA, 10'h3FE, 11'd1, 1'b0};
        vecs[3] = '{1'b0, 10'h000, 16'h0F0F, 16'hF0F0, 10'h3FF, 11'd2, 1'b1};
        exp_writes = 0;

        // Reset state
        tick(3);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_half_sel", half_sel, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_full", full, 0);
        chk("rst_chksum", chksum, 0);
        rst = 1'b0;
        tick(2);

        // Debounce: bouncing rise gives one press 7 cycles after the final rise,
        // seen here as the write one cycle later.
        start_session(10'h100);
        press_key(16'h1111);
        chk("deb_half_sel", half_sel, 1);
        sw = 16'h2222;
        exp_q.push_back('{10'h100, 32'h22221111});
        exp_writes++;
        for (int i = 0; i < 9; i++) begin
            button = i[0];
            tick(2);
        end
        button = 1'b1;
        k = 0;
        while (k < 20) begin
            tick(1);
            k++;
            if (mem_we) break;
        end
        chk("deb_latency", k, DB + 4);
        tick(10);
        for (int i = 0; i < 10; i++) begin
            button = ~i[0];
            tick(2);
        end
        button = 1'b0;
        tick(10);
        chk("deb_word_count", word_count, 1);
        chk("deb_half_sel_after", half_sel, 0);
        chk("deb_writes", n_writes, exp_writes);

        // Table-driven word entry, including the top-of-memory boundary.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].new_sess) start_session(vecs[i].add);
            press_key(vecs[i].lo);
            exp_q.push_back('{vecs[i].exp_addr, {vecs[i].hi, vecs[i].lo}});
            exp_writes++;
            press_key(vecs[i].hi);
            chk($sformatf("vec%0d_word_count", i), word_count, vecs[i].exp_wc);
            chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
            chk($sformatf("vec%0d_half_sel", i), half_sel, 0);
            chk($sformatf("vec%0d_cpu_hold", i), cpu_hold, 1);
        end

        // Presses in FULL are ignored.
        press_key(16'h7777);
        press_key(16'h8888);
        chk("full_word_count", word_count, 2);
        chk("full_still", full, 1);
        chk("full_writes", n_writes, exp_writes);
        load_en = 1'b0;
        tick(1);
        chk("full_exit_cpu_hold", cpu_hold, 0);
        chk("full_exit_full", full, 0);

        // Abort after the low half: no write, hold released next cycle.
        start_session(10'h077);
        press_key(16'hDEAD);
        load_en = 1'b0;
        tick(1);
        chk("abort_cpu_hold", cpu_hold, 0);
        press_key(16'hBEEF);
        chk("abort_writes", n_writes, exp_writes);
        add = 10'h020;
        load_en = 1'b1;
        tick(2);
        press_key(16'h4444);
        exp_q.push_back('{10'h020, 32'h33334444});
        exp_writes++;
        press_key(16'h3333);
        chk("abort_word_count", word_count, 1);

        // Reset in HI: partial word dropped.
        press_key(16'h9999);
        chk("rst_mid_half_sel_pre", half_sel, 1);
        rst = 1'b1;
        load_en = 1'b0;
        tick(1);
        chk("rst_mid_cpu_hold", cpu_hold, 0);
        chk("rst_mid_half_sel", half_sel, 0);
        chk("rst_mid_word_count", word_count, 0);
        rst = 1'b0;
        press_key(16'h6666);
        chk("rst_mid_writes", n_writes, exp_writes);

        // Checksum
        start_session(10'h200);
        press_key(16'h0001);
        exp_q.push_back('{10'h200, 32'h00020001});
        exp_writes++;
        press_key(16'h0002);
        press_key(16'h0003);
        exp_q.push_back('{10'h201, 32'hFFFF0003});
        exp_writes++;
        press_key(16'hFFFF);
        load_en = 1'b0;
        tick(2);
`ifdef LOADER_CHECKSUM_EN
        chk("chksum", chksum, 16'h0005);
`else
        chk("chksum", chksum, 16'h0000);
`endif
        chk("final_word_count", word_count, 2);
        chk("final_writes", n_writes, exp_writes);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
